// File: rtl/reg_dumper_pkg.sv
// reg_dumper_pkg: widths and FSM state encoding that the register dumper and its
// users share.
//   AW      - register address width (2**AW registers)
//   DW      - register data width
//   state_e - dump sequencer states
package reg_dumper_pkg;

    localparam int unsigned AW = 3;
    localparam int unsigned DW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend,
        StDone
    } state_e;

endpackage

// File: rtl/reg_dumper.sv
// reg_dumper: walks an external register file from first_addr to last_addr
// (wrapping modulo 2**AW) and streams each (address, data) pair out through a
// valid/ready handshake. A register's contents are captured at the moment its
// read happens, so later writes to the same register do not change the item
// already on the output.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   request a dump (only looked at while idle)
//   first_addr in   first register to dump, captured on an accepted start
//   last_addr  in   last register to dump, captured on an accepted start
//   ra         out  register file read address (always the current index)
//   rd         in   register file read data for ra, same cycle
//   out_valid  out  out_addr/out_data hold an item
//   out_ready  in   consumer takes the item when high together with out_valid
//   out_addr   out  register index of the current item
//   out_data   out  register contents of the current item
//   busy       out  a dump is in progress (LOAD or SEND)
//   done       out  one-cycle pulse after the final item is taken
module reg_dumper #(
    parameter int unsigned AW = reg_dumper_pkg::AW,
    parameter int unsigned DW = reg_dumper_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW-1:0] last_addr,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    import reg_dumper_pkg::*;

    state_e        state_q, state_d;
    logic [AW-1:0] cur_q, cur_d;
    logic [AW-1:0] last_q, last_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_addr_q, out_addr_d;
    logic [DW-1:0] out_data_q, out_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            last_q      <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Snapshot the register here; this is the only cycle rd is used.
                out_data_d  = rd;
                out_addr_d  = cur_q;
                out_valid_d = 1'b1;
                state_d     = StSend;
            end
            StSend: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (cur_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        // Natural overflow gives the wrap from the top index to 0.
                        cur_d   = cur_q + AW'(1);
                        state_d = StLoad;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ra        = cur_q;
    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_data  = out_data_q;
    assign busy      = (state_q == StLoad) || (state_q == StSend);
    assign done      = (state_q == StDone);

endmodule
